// File: rtl/pdm_cic_pkg.sv
// pdm_cic_pkg: shared widths, full-scale and PDM bit polarity for the PDM CIC blocks
package pdm_cic_pkg;
  localparam int DEF_DW = 16;
  localparam int DEF_LOG2R = 5;
  localparam int W = DEF_DW + 2 * DEF_LOG2R;
  localparam int FS = 2 ** (DEF_DW - 1);
  localparam logic PDM_POS = 1'b0;
  localparam logic PDM_NEG = 1'b1;
endpackage

// File: rtl/pdm_cic_interp_sd_mod1.sv
// sd_mod1: first-order sigma-delta modulator, DW-bit signed level to 1-bit PDM
module sd_mod1
  import pdm_cic_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] v,
  output logic                 dout
);
  localparam logic signed [DW+2:0] FSW = {4'b0001, {(DW-1){1'b0}}};
  logic signed [DW+1:0] acc;
  logic signed [DW+2:0] sum;
  logic q;
  assign q = acc[DW+1];
  assign sum = (DW+3)'(acc) + (DW+3)'(v) + (q ? FSW : -FSW);
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      dout <= PDM_POS;
    end else begin
      acc <= sum[DW+1:0];
      dout <= q ? PDM_NEG : PDM_POS;
      assert (sum[DW+2] == sum[DW+1]);
    end
  end
endmodule

// File: rtl/pdm_cic_interp.sv
// pdm_cic_interp: PCM sample in, 2-stage CIC x2^LOG2R interpolation, 1-bit PDM out
module pdm_cic_interp
  import pdm_cic_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int LOG2R = DEF_LOG2R
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 dout,
  output logic                 underrun
);
  localparam int IW = DW + 2 * LOG2R;
  logic [LOG2R-1:0] phase;
  logic signed [DW-1:0] hold, last, v;
  logic hold_full, frame, xfer;
  logic signed [IW-1:0] x, x_prev, c1, c1_prev, c2, u, i1, i2, i2_s;
  assign din_ready = !hold_full;
  assign xfer = din_valid && din_ready;
  assign frame = phase == '0;
  assign x = hold_full ? IW'(hold) : IW'(last);
  assign u = phase == LOG2R'(1) ? c2 : '0;
  assign i2_s = i2 >>> LOG2R;
  // clamp the rescaled integrator to the DW-bit modulator range
  assign v = (&i2_s[IW-1:DW-1] || ~|i2_s[IW-1:DW-1]) ? i2_s[DW-1:0]
           : {i2_s[IW-1], {(DW-1){~i2_s[IW-1]}}};
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
      hold <= '0;
      hold_full <= 1'b0;
      last <= '0;
      underrun <= 1'b0;
      x_prev <= '0;
      c1 <= '0;
      c1_prev <= '0;
      c2 <= '0;
      i1 <= '0;
      i2 <= '0;
    end else begin
      phase <= phase + LOG2R'(1);
      if (xfer) hold <= din;
      hold_full <= xfer || (hold_full && !frame);
      underrun <= frame && !hold_full;
      if (frame) begin
        if (hold_full) last <= hold;
        c1 <= x - x_prev;
        x_prev <= x;
        c2 <= c1 - c1_prev;
        c1_prev <= c1;
      end
      i1 <= i1 + u;
      i2 <= i2 + i1;
    end
  end
  sd_mod1 #(.DW(DW)) u_sd (
    .clk(clk),
    .reset(reset),
    .v(v),
    .dout(dout)
  );
endmodule

// File: tb/tb_pdm_cic_interp.sv
// tb_pdm_cic_interp: directed scenario tests for the PDM CIC interpolator
module tb_pdm_cic_interp;
  import pdm_cic_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic signed [DEF_DW-1:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready, dout, underrun;
  int edges = 0;
  int vectors = 0;
  int miscompares = 0;

  pdm_cic_interp dut (
    .clk(clk),
    .reset(reset),
    .din(din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .dout(dout),
    .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= reset ? 0 : edges + 1;

  task do_reset;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task wait_phase(input int p);
    for (int k = 0; k < 64 && edges % 32 != p; k++) @(negedge clk);
  endtask

  task test_reset;
    logic [2:0] exp;
    din_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({dout, underrun, din_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 001", {dout, underrun, din_ready});
    end
    reset = 1'b0;
    for (int n = 1; n <= 96; n++) begin
      @(negedge clk);
      exp = {(n - 1) % 2 == 1, (n - 1) % 32 == 0, 1'b1};
      vectors++;
      if ({dout, underrun, din_ready} !== exp) begin
        miscompares++;
        $display("FAIL idle_toggle cycle %0d: got %b want %b", n, {dout, underrun, din_ready}, exp);
      end
    end
  endtask

  task test_half_scale;
    int zeros, urs;
    din = DEF_DW'(FS / 2);
    din_valid = 1'b1;
    do_reset();
    urs = 0;
    for (int n = 0; n < 160; n++) begin
      @(negedge clk);
      if (edges >= 2 && underrun) urs++;
    end
    vectors++;
    if (urs !== 0) begin
      miscompares++;
      $display("FAIL half_settle_underrun: got %0d pulses want 0", urs);
    end
    for (int w = 0; w < 4; w++) begin
      zeros = 0;
      urs = 0;
      for (int n = 0; n < 32; n++) begin
        @(negedge clk);
        zeros += int'(dout == PDM_POS);
        urs += int'(underrun);
      end
      vectors++;
      if (zeros < 23 || zeros > 25 || urs != 0) begin
        miscompares++;
        $display("FAIL half_density win %0d: got %0d zeros %0d underruns want 24+-1 zeros 0 underruns", w, zeros, urs);
      end
    end
  endtask

  task test_full_neg;
    int zeros;
    din = DEF_DW'(-FS);
    repeat (192) @(negedge clk);
    for (int w = 0; w < 4; w++) begin
      zeros = 0;
      for (int n = 0; n < 32; n++) begin
        @(negedge clk);
        zeros += int'(dout == PDM_POS);
      end
      vectors++;
      if (zeros > 1) begin
        miscompares++;
        $display("FAIL negfs_density win %0d: got %0d zeros want <=1", w, zeros);
      end
    end
  endtask

  task test_underrun;
    int zeros, urs, misplaced;
    din = DEF_DW'(FS / 4);
    din_valid = 1'b1;
    repeat (192) @(negedge clk);
    wait_phase(2);
    din_valid = 1'b0;
    urs = 0;
    misplaced = 0;
    for (int w = 0; w < 6; w++) begin
      if (w == 5) din_valid = 1'b1;
      zeros = 0;
      for (int n = 0; n < 32; n++) begin
        @(negedge clk);
        zeros += int'(dout == PDM_POS);
        urs += int'(underrun);
        if (underrun && (edges - 1) % 32 != 0) misplaced++;
      end
      vectors++;
      if (zeros < 19 || zeros > 21) begin
        miscompares++;
        $display("FAIL hold_last_density win %0d: got %0d zeros want 20+-1", w, zeros);
      end
    end
    vectors++;
    if (urs !== 4 || misplaced !== 0) begin
      miscompares++;
      $display("FAIL underrun_count: got %0d pulses %0d off-frame want 4 and 0", urs, misplaced);
    end
  endtask

  task test_back_to_back;
    int accepts, lows, urs, zeros;
    din = DEF_DW'(FS / 4);
    din_valid = 1'b1;
    accepts = 0;
    lows = 0;
    urs = 0;
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      accepts += int'(din_valid && din_ready);
      lows += int'(!din_ready);
      urs += int'(underrun);
    end
    vectors++;
    if (accepts !== 4 || lows !== 124 || urs !== 0) begin
      miscompares++;
      $display("FAIL backpressure: got %0d accepts %0d low %0d underruns want 4 124 0", accepts, lows, urs);
    end
    wait_phase(2);
    din_valid = 1'b0;
    repeat (62) @(negedge clk);
    din = DEF_DW'(-FS / 2);
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    vectors++;
    if ({underrun, din_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL phase0_transfer: got underrun,ready=%b want 10", {underrun, din_ready});
    end
    lows = 0;
    for (int n = 0; n < 31; n++) begin
      @(negedge clk);
      lows += int'(!din_ready);
    end
    @(negedge clk);
    vectors++;
    if (lows !== 31 || din_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL phase0_hold: got %0d low ready=%b want 31 low then 1", lows, din_ready);
    end
    repeat (160) @(negedge clk);
    zeros = 0;
    for (int n = 0; n < 32; n++) begin
      @(negedge clk);
      zeros += int'(dout == PDM_POS);
    end
    vectors++;
    if (zeros < 7 || zeros > 9) begin
      miscompares++;
      $display("FAIL phase0_sample_kept: got %0d zeros want 8+-1", zeros);
    end
  endtask

  task test_reset_midframe;
    logic [2:0] exp;
    din = DEF_DW'(FS / 2);
    din_valid = 1'b1;
    repeat (40) @(negedge clk);
    wait_phase(17);
    reset = 1'b1;
    din_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({dout, underrun, din_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL midframe_reset: got %b want 001", {dout, underrun, din_ready});
    end
    reset = 1'b0;
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      exp = {(n - 1) % 2 == 1, (n - 1) % 32 == 0, 1'b1};
      vectors++;
      if ({dout, underrun, din_ready} !== exp) begin
        miscompares++;
        $display("FAIL restart_toggle cycle %0d: got %b want %b", n, {dout, underrun, din_ready}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_half_scale();
    test_full_neg();
    test_underrun();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
